// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   state_t           - loader FSM states
//   IMEM_WORD_BYTES   - bytes per instruction word
//   IMEM_ADDR_STRIDE  - byte-address step between consecutive words
//   word_addr()       - byte address of word k relative to a base
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam int          IMEM_WORD_BYTES  = 4;
    localparam logic [31:0] IMEM_ADDR_STRIDE = 32'd4;

    // Same PC-indexed addressing as the fetch side: base + 4*k, modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + idx * IMEM_ADDR_STRIDE;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream input and the instruction-memory write port.
//   in_valid / in_data / in_ready : byte stream (valid/ready handshake)
//   wr_en / wr_addr / wr_data     : memory write port, one strobe per word
// Modports:
//   master - stream source and memory side (drives bytes, observes writes)
//   slave  - the loader (accepts bytes, drives writes)
// ---------------------------------------------------------------------------
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                         in_valid;
    logic [7:0]                   in_data;
    logic                         in_ready;
    logic                         wr_en;
    logic [31:0]                  wr_addr;
    logic [IMEM_WORD_BYTES*8-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
// Packs bytes little-endian into 32-bit words. The first three bytes of a
// word are held in lane registers; the fourth byte is forwarded straight
// into word[31:24] so the complete word is available in the cycle that
// byte is accepted (word_valid is combinational).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear of the byte counter and lanes
//   byte_valid  - a byte is accepted this cycle
//   byte_data   - the accepted byte
//   word_valid  - this byte completes a word
//   word        - packed word (valid while word_valid)
// ---------------------------------------------------------------------------
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_LANE = 2'(IMEM_WORD_BYTES - 1);

    logic [1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (byte_valid) begin
            cnt_reg <= (cnt_reg == LAST_LANE) ? 2'd0 : cnt_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IMEM_WORD_BYTES - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (clr) begin
                    lane_reg <= '0;
                end else if (byte_valid && cnt_reg == 2'(gi)) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign word[31:24] = byte_data;
    assign word_valid  = byte_valid && (cnt_reg == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Programs the instruction memory from a length-prefixed little-endian byte
// stream: two length bytes (word count, LSB first) followed by 4*len data
// bytes. Each completed word is written at BASE_ADDR + 4*k. The core is
// held in reset until the image has been written completely.
// Parameters:
//   DEPTH_WORDS - instruction memory capacity in words
//   BASE_ADDR   - byte address of the first word
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - arm a new load (ignored while busy)
//   busy        - load in progress
//   done        - last load completed cleanly (sticky until next start)
//   err         - length exceeded DEPTH_WORDS (sticky until next start)
//   core_rst_n  - active-low core reset, released only when done
//   bus         - byte stream in, memory write port out
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         core_rst_n,
    imem_loader_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

    state_t            state_reg, state_next;
    logic [15:0]       len_reg, len_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;

    logic              wr_en_reg;
    logic [31:0]       wr_addr_reg;
    logic [31:0]       wr_data_reg;

    logic              accept;
    logic              start_ok;
    logic              image_full;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       len_full;

    assign accept     = bus.in_valid && bus.in_ready;
    assign start_ok   = start && !busy;
    assign len_full   = {bus.in_data, len_reg[7:0]};

    // Once every word has been handed to the write port, the loader spends
    // one more cycle in DATA so that done rises after the final wr_en pulse.
    // Bytes offered during that cycle are handshaken but not packed.
    assign image_full = (32'(idx_reg) == 32'(len_reg));
    assign pack_valid = accept && (state_reg == DATA) && !image_full;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .byte_valid (pack_valid),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;

        unique case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = LEN_LO;
                    len_next   = '0;
                    idx_next   = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_next[7:0] = bus.in_data;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_next = len_full;
                    if (len_full == 16'd0) begin
                        state_next = DONE;
                    end else if (32'(len_full) > 32'(DEPTH_WORDS)) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (image_full) begin
                    state_next = DONE;
                end else if (word_valid) begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port is registered: the strobe appears the cycle after the
    // fourth byte of a word, address/data hold until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= word_valid;
            if (word_valid) begin
                wr_addr_reg <= word_addr(BASE_ADDR, 32'(idx_reg));
                wr_data_reg <= word;
            end
        end
    end

    assign busy         = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                          (state_reg == DATA);
    assign bus.in_ready = busy;
    assign done         = (state_reg == DONE);
    assign err          = (state_reg == ERR);
    assign core_rst_n   = (state_reg == DONE);

    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. A behavioural model derives the
// expected write list (address, word, cycle) and final flags from the byte
// image, the length and the cycle each byte was accepted.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err, core_rst_n;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst_n (core_rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          done_cyc = -1;
    logic        done_q = 1'b0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    logic [7:0]  img[0:255];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            wq_cyc.push_back(cyc);
            $display("cycle %0d: write addr=0x%08h data=0x%08h", cyc, bus.wr_addr, bus.wr_data);
        end
        if (done === 1'b1 && done_q !== 1'b1) done_cyc = cyc;
        done_q = done;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start,
                             output int acc_cyc);
        logic rdy;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        start        = with_start;
        acc_cyc      = -1;
        for (int w = 0; w < 20 && acc_cyc < 0; w++) begin
            rdy = bus.in_ready;
            tick();
            start = 1'b0;
            if (rdy === 1'b1) acc_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (acc_cyc < 0) check("byte_accepted", 32'(acc_cyc >= 0), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready",   32'(bus.in_ready), 32'd0);
        check("rst_wr_en",      32'(bus.wr_en),    32'd0);
        check("rst_wr_addr",    bus.wr_addr,       32'd0);
        check("rst_wr_data",    bus.wr_data,       32'd0);
        check("rst_busy",       32'(busy),         32'd0);
        check("rst_done",       32'(done),         32'd0);
        check("rst_err",        32'(err),          32'd0);
        check("rst_core_rst_n", 32'(core_rst_n),   32'd0);
    endtask

    // gap_mode < 0: random 0..3 idle cycles before each data byte.
    // start_at: data byte index that carries a concurrent start pulse (-1: none).
    task automatic run_image(input int len, input int gap_mode, input int start_at);
        int          acc;
        int          gap;
        int          exp_cyc[$];
        logic [31:0] exp_word;
        logic [15:0] len16;
        len16 = 16'(len);
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cyc = -1;
        $display("load: len=%0d gap_mode=%0d start_at=%0d", len, gap_mode, start_at);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("armed_busy",       32'(busy),         32'd1);
        check("armed_in_ready",   32'(bus.in_ready), 32'd1);
        check("armed_done",       32'(done),         32'd0);
        check("armed_err",        32'(err),          32'd0);
        check("armed_core_rst_n", 32'(core_rst_n),   32'd0);

        send_byte(len16[7:0], 0, 1'b0, acc);
        send_byte(len16[15:8], 0, 1'b0, acc);

        if (len == 0) begin
            check("len0_done_cycle", 32'(done_cyc),     32'(acc));
            check("len0_done",       32'(done),         32'd1);
            check("len0_core_rst_n", 32'(core_rst_n),   32'd1);
            check("len0_in_ready",   32'(bus.in_ready), 32'd0);
            repeat (3) tick();
            check("len0_no_write",   32'(wq_addr.size()), 32'd0);
        end else if (len > DEPTH) begin
            check("err_flag",      32'(err),          32'd1);
            check("err_in_ready",  32'(bus.in_ready), 32'd0);
            check("err_busy",      32'(busy),         32'd0);
            check("err_done",      32'(done),         32'd0);
            bus.in_valid = 1'b1;
            repeat (8) begin
                bus.in_data = 8'($urandom);
                tick();
            end
            bus.in_valid = 1'b0;
            tick();
            check("err_no_write",    32'(wq_addr.size()), 32'd0);
            check("err_core_rst_n",  32'(core_rst_n),     32'd0);
            check("err_sticky",      32'(err),            32'd1);
        end else begin
            for (int i = 0; i < 4 * len; i++) begin
                gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
                send_byte(img[i], gap, (i == start_at), acc);
                if (i % 4 == 3) exp_cyc.push_back(acc);
            end
            for (int w = 0; w < 10 && done_cyc < 0; w++) tick();
            check("write_count", 32'(wq_addr.size()), 32'(len));
            for (int k = 0; k < len && k < wq_addr.size(); k++) begin
                exp_word = 32'(img[4*k]) + 32'(img[4*k+1]) * 32'd256 +
                           32'(img[4*k+2]) * 32'd65536 + 32'(img[4*k+3]) * 32'd16777216;
                check($sformatf("wr_addr[%0d]", k),  wq_addr[k],       32'(4 * k));
                check($sformatf("wr_data[%0d]", k),  wq_data[k],       exp_word);
                check($sformatf("wr_cycle[%0d]", k), 32'(wq_cyc[k]),   32'(exp_cyc[k]));
            end
            check("done_cycle",      32'(done_cyc),     32'(exp_cyc[len-1] + 1));
            check("done_flag",       32'(done),         32'd1);
            check("done_core_rst_n", 32'(core_rst_n),   32'd1);
            check("done_busy",       32'(busy),         32'd0);
            check("done_in_ready",   32'(bus.in_ready), 32'd0);
            check("done_err",        32'(err),          32'd0);
            // Bytes in DONE are refused; the write port keeps its last values.
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            repeat (3) tick();
            bus.in_valid = 1'b0;
            check("hold_no_extra_write", 32'(wq_addr.size()), 32'(len));
            check("hold_wr_addr",        bus.wr_addr,         32'(4 * (len - 1)));
            check("hold_wr_data",        bus.wr_data,         exp_word);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    endtask

    task automatic fill_fixed();
        img[0] = 8'h33; img[1] = 8'h86; img[2] = 8'h9C; img[3] = 8'h01;
        img[4] = 8'hB3; img[5] = 8'h02; img[6] = 8'h34; img[7] = 8'h40;
    endtask

    initial begin
        int acc;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state.
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Reference image, back-to-back.
        fill_fixed();
        run_image(2, 0, -1);

        // Empty image.
        run_image(0, 0, -1);

        // Oversized length, then one using the high length byte.
        run_image(DEPTH + 1, 0, -1);
        run_image(300, 0, -1);

        // Reference image with in_valid toggling 1,0,0.
        fill_fixed();
        run_image(2, 2, -1);

        // Reset in the middle of DATA after six bytes.
        fill_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'd4, 0, 1'b0, acc);
        send_byte(8'd0, 0, 1'b0, acc);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-load");
        check_reset_vals();
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        check("idle_refuses_byte", 32'(busy), 32'd0);
        fill_random();
        run_image(4, 0, -1);

        // Start pulses during DATA and with the final byte are ignored.
        fill_random();
        run_image(8, 0, 5);
        fill_random();
        run_image(3, 1, 11);

        // Capacity boundary and randomized loads.
        fill_random();
        run_image(DEPTH, 0, -1);
        fill_random();
        run_image(1, -1, -1);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_image(int'($urandom_range(1, DEPTH)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the core's instruction memory: the write-side counterpart of the PC-indexed instruction memory read port. It receives a length-prefixed little-endian byte stream over a valid/ready interface, packs each 4 bytes into a 32-bit word and issues one write per word to the memory write port at byte addresses 0, 4, 8, … (the same PC-indexed addressing the fetch side uses). It holds the core in reset until the image is complete.

## Interface
- `DEPTH_WORDS`, default 64: instruction memory capacity in words.
- `BASE_ADDR`, default 32'h0: byte address of the first word written.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: arm a new load; single-cycle pulse.
- `in_valid` input 1: `in_data` holds a valid byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: memory write strobe, one cycle per word.
- `wr_addr` output 32: byte address of the write.
- `wr_data` output 32: instruction word to write.
- `busy` output 1: load in progress.
- `done` output 1: last load completed cleanly; sticky until the next `start`.
- `err` output 1: length exceeded `DEPTH_WORDS`; sticky until the next `start`.
- `core_rst_n` output 1: active-low reset to the core; released only in DONE.

## Operation
- A byte transfers when `in_valid && in_ready` at a rising clock edge.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR. Reset state is IDLE.
- IDLE, DONE, ERR: `start` moves to LEN_LO, clears `done`/`err`, clears the byte and word counters, and drives `core_rst_n` low.
- LEN_LO: the accepted byte is `len[7:0]`; go to LEN_HI.
- LEN_HI: the accepted byte is `len[15:8]`.
  - If `len` == 0: go to DONE.
  - If `len` > `DEPTH_WORDS`: go to ERR.
  - Otherwise: go to DATA.
- DATA: bytes are packed little-endian, so the first byte goes to `word[7:0]` and the fourth to `word[31:24]`.
  - On the 4th byte of a word, issue a write with `wr_data`=word and `wr_addr`=`BASE_ADDR`+4·k (k = word index), then increment k.
  - After word `len`−1 is written, go to DONE.
- `in_ready` is 1 only in LEN_LO, LEN_HI and DATA. It is combinational from state, so there are no stalls within a load.
- `busy` is 1 in LEN_LO, LEN_HI and DATA.
- `start` is ignored while `busy`.
- Bytes presented in IDLE, DONE or ERR are not accepted.
- ERR: `core_rst_n` stays low, no writes occur, and `err`=1.
- Counters:
  - `len` is 16 bits.
  - The word index is wide enough for `DEPTH_WORDS`.
  - `wr_addr` is 32-bit modulo arithmetic; no wrap is possible because `len` ≤ `DEPTH_WORDS`.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `core_rst_n`=0. State is IDLE.
- `wr_en`, `wr_addr` and `wr_data` are registered.
  - `wr_en` pulses high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - `wr_addr` and `wr_data` hold their values until the next write.
- `done` and `core_rst_n`=1 assert in the cycle after the final write pulse; for `len`=0, in the cycle after the LEN_HI byte is accepted.
- `err` asserts in the cycle after the LEN_HI byte is accepted.
- Back-to-back bytes at one per cycle produce one write every 4 cycles. `in_valid` gaps of any length stall packing with no loss.
- `rst_n` asserted mid-load aborts immediately to reset values. A partially written image is not invalidated; the core stays in reset.
- A `start` in the same cycle as the final byte is ignored, because the block is still `busy`.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR);
  - the constant `IMEM_WORD_BYTES`=4;
  - the address stride of 4.
- `DEPTH_WORDS` default matches the instruction memory depth of 64 words.
- One sub-module is natural: `byte_packer`, a 4-byte shift/pack register with a byte counter and a `word_valid` output. The FSM and the address counter stay in the top level.

## Test plan
- `start`, then bytes 02 00 | 33 86 9C 01 | B3 02 34 40 back-to-back:
  - writes 0x019C8633 at addr 0, then 0x403402B3 at addr 4;
  - `done`=1 and `core_rst_n`=1 one cycle after the second `wr_en`.
- `start`, then bytes 00 00: no `wr_en`; `done`=1 one cycle after the second byte.
- `start`, then bytes 41 00 (`len`=65 > 64):
  - `err`=1 and `in_ready`=0;
  - following bytes are ignored, no writes occur, and `core_rst_n` stays 0.
- Same image as the first test with `in_valid` toggling 1,0,0,1…: identical writes and data, with later pulse times.
- `rst_n` pulsed low after 6 DATA bytes:
  - all outputs return to reset values and the state is IDLE;
  - a new `start` and a full image then load correctly from addr 0.
- `start` pulsed mid-DATA: ignored, and the load completes unchanged.
